// File: rtl/alu_exec_16.sv
// alu_exec_16: 16-bit two-register ALU execution stage.
// E holds the accepted operation and drives nibble generate/propagate terms
// to an external 4-bit carry lookahead generator. The generator's mid-word and
// carry-out come back combinationally within the same cycle. R holds the
// result and flags behind a valid/ready handshake. carry_flag persists the
// arithmetic carry for ADC/SBB chains.
module alu_exec_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       g_n,
  output logic [3:0]       p_n,
  output logic             cn_n,
  input  logic             cn2_n,
  input  logic             cn4_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             carry_flag
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADC   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SBB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;

  logic [2:0]       e_op;
  logic [WIDTH-1:0] e_a;
  logic [WIDTH-1:0] e_b;
  logic             e_valid;

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_valid;

  logic             accept;
  logic             advance;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [3:0]       gen;
  logic [3:0]       prop;
  logic [4:0]       s0;
  logic [3:0]       s1;
  logic [4:0]       s2;
  logic [3:0]       s3;
  logic             c1;
  logic             c2;
  logic             c3;
  logic             c_out;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;

  assign advance  = e_valid & (~r_valid | out_ready);
  assign in_ready = ~e_valid | advance;
  assign accept   = in_valid & in_ready;

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;

  // Operand conditioning: subtraction inverts B, carry-in selected by opcode.
  always_comb begin
    is_arith = ~e_op[2];
    b_eff    = ((e_op == OP_SUB) || (e_op == OP_SBB)) ? ~e_b : e_b;
    c0       = 1'b0;
    case (e_op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      OP_ADC,
      OP_SBB:  c0 = carry_flag;
      default: c0 = 1'b0;
    endcase
  end

  // Per-nibble generate/propagate, taken only from the E register.
  always_comb begin
    logic [3:0] a_n;
    logic [3:0] b_n;
    a_n  = '0;
    b_n  = '0;
    gen  = '0;
    prop = '0;
    for (int i = 0; i < 4; i++) begin
      a_n     = e_a[4*i +: 4];
      b_n     = b_eff[4*i +: 4];
      gen[i]  = ({1'b0, a_n} + {1'b0, b_n}) > 5'd15;
      prop[i] = &(a_n | b_n);
    end
  end

  assign g_n  = ~gen;
  assign p_n  = ~prop;
  assign cn_n = ~c0;

  // Nibble sums: ripple inside each half, generator supplies c2 and carry-out.
  always_comb begin
    s0    = {1'b0, e_a[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, c0};
    c1    = s0[4];
    s1    = e_a[7:4] + b_eff[7:4] + {3'd0, c1};
    c2    = ~cn2_n;
    s2    = {1'b0, e_a[11:8]} + {1'b0, b_eff[11:8]} + {4'd0, c2};
    c3    = s2[4];
    s3    = e_a[15:12] + b_eff[15:12] + {3'd0, c3};
    c_out = ~cn4_n;
    sum   = {s3, s2[3:0], s1, s0[3:0]};
  end

  // Result mux and carry/overflow; logic ops never report C or V.
  always_comb begin
    result = sum;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (e_op)
      OP_AND:  result = e_a & e_b;
      OP_OR:   result = e_a | e_b;
      OP_XOR:  result = e_a ^ e_b;
      OP_ADD,
      OP_ADC,
      OP_SUB,
      OP_SBB: begin
        result = sum;
        flag_c = c_out;
        flag_v = (e_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != e_a[WIDTH-1]);
      end
      default: result = e_a;
    endcase
  end

  // E register: load on accept, empty when its op advances with nothing behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_op    <= OP_ADD;
      e_a     <= '0;
      e_b     <= '0;
    end else if (accept) begin
      e_valid <= 1'b1;
      e_op    <= in_op;
      e_a     <= in_a;
      e_b     <= in_b;
    end else if (advance) begin
      e_valid <= 1'b0;
    end
  end

  // R register: capture on advance, drain on output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (advance) begin
      r_valid  <= 1'b1;
      r_result <= result;
      r_flags  <= {result[WIDTH-1], (result == '0), flag_c, flag_v};
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Persistent carry: only arithmetic ops update it, at the edge they leave E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_flag <= 1'b0;
    end else if (advance && is_arith) begin
      carry_flag <= flag_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_16.sv
// Self-checking bench for alu_exec_16 with a 74182-style lookahead generator
// model and an arithmetic reference model of the ALU.
module tb_alu_exec_16;

  localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBB = 3'd3;
  localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, PASSA = 3'd7;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  g_n;
  logic [3:0]  p_n;
  logic        cn_n;
  logic        cn2_n;
  logic        cn4_n;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic        carry_flag;

  alu_exec_16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .g_n(g_n), .p_n(p_n), .cn_n(cn_n), .cn2_n(cn2_n), .cn4_n(cn4_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .carry_flag(carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden lookahead generator, active-low pins, purely combinational.
  logic [3:0] gg, pp;
  logic       cin;
  assign gg    = ~g_n;
  assign pp    = ~p_n;
  assign cin   = ~cn_n;
  assign cn2_n = ~(gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin));
  assign cn4_n = ~(gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                   (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & cin));

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
    logic        cf;
  } exp_t;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
    logic [31:0] cyc;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  exp_t        mon_e;
  logic        m_cf;
  logic        rand_ready;
  logic [31:0] cyc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, carries applied in program order.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] bb;
    logic        c0, c, v;
    logic [16:0] full;
    bb   = (op == SUB || op == SBB) ? ~b : b;
    c0   = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : m_cf;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      AND_:  e.res = a & b;
      OR_:   e.res = a | b;
      XOR_:  e.res = a ^ b;
      PASSA: e.res = a;
      default: begin
        e.res = full[15:0];
        c     = full[16];
        v     = (a[15] == bb[15]) && (full[15] != a[15]);
        m_cf  = c;
      end
    endcase
    e.flg = {e.res[15], (e.res == 16'd0), c, v};
    e.cf  = m_cf;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every handshake is compared with the model and logged.
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 32'(out_result), 32'(mon_e.res));
        chk("flags", 32'(out_flags), 32'(mon_e.flg));
        chk("carry_flag", 32'(carry_flag), 32'(mon_e.cf));
      end
      obs_q.push_back('{res: out_result, flg: out_flags, cyc: cyc});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    bit done;
    n    = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        exp_q.push_back(model(op, a, b));
        done = 1;
      end else begin
        n++;
        if (n > 200) begin
          chk("issue_timeout", 32'(in_ready), 32'd1);
          done = 1;
        end
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_obs(input int idx, input logic [15:0] res, input logic [3:0] flg);
    if (idx < obs_q.size()) begin
      chk($sformatf("obs%0d_result", idx), 32'(obs_q[idx].res), 32'(res));
      chk($sformatf("obs%0d_flags", idx), 32'(obs_q[idx].flg), 32'(flg));
    end else begin
      chk($sformatf("obs%0d_missing", idx), 32'(obs_q.size()), 32'(idx + 1));
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc        = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_op      = ADD;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    m_cf       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_g_n", 32'(g_n), 32'hF);
    chk("rst_p_n", 32'(p_n), 32'hF);
    chk("rst_cn_n", 32'(cn_n), 32'd1);

    // Overflow into the sign bit, with latency check.
    issue(ADD, 16'h7FFF, 16'h0001);
    @(negedge clk); #2;
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #2;
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    chk("ovf_result", 32'(out_result), 32'h8000);
    chk("ovf_flags", 32'(out_flags), 32'h9);
    drain();

    obs_q.delete();
    issue(SUB, 16'h1234, 16'h1234);
    issue(SUB, 16'h0000, 16'h0001);
    drain();
    chk("sub_count", 32'(obs_q.size()), 32'd2);
    check_obs(0, 16'h0000, 4'h6);
    check_obs(1, 16'hFFFF, 4'h8);

    obs_q.delete();
    issue(ADD, 16'hFFFF, 16'h0001);
    issue(ADC, 16'h0000, 16'h0000);
    issue(XOR_, 16'h00FF, 16'h0F0F);
    issue(ADC, 16'h0000, 16'h0000);
    drain();
    chk("b2b_count", 32'(obs_q.size()), 32'd4);
    check_obs(0, 16'h0000, 4'h6);
    check_obs(1, 16'h0001, 4'h0);
    check_obs(2, 16'h0FF0, 4'h0);
    check_obs(3, 16'h0000, 4'h4);
    chk("b2b_carry_end", 32'(carry_flag), 32'd0);

    obs_q.delete();
    issue(ADD, 16'h00FF, 16'h0001);
    issue(ADD, 16'h0FFF, 16'h0001);
    issue(ADD, 16'h000F, 16'h0001);
    drain();
    check_obs(0, 16'h0100, 4'h0);
    check_obs(1, 16'h1000, 4'h0);
    check_obs(2, 16'h0010, 4'h0);

    // Backpressure: R and E fill, third op stalls, then all emerge in order.
    obs_q.delete();
    @(negedge clk);
    out_ready = 1'b0;
    issue(ADD, 16'h0001, 16'h0001);
    issue(OR_, 16'h00F0, 16'h0F00);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = AND_;
    in_a     = 16'hF0F0;
    in_b     = 16'hFF00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'(out_result), 32'h0002);
      chk("bp_hold_g_n", 32'(g_n), 32'hF);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(model(AND_, 16'hF0F0, 16'hFF00));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(obs_q.size()), 32'd3);
    check_obs(0, 16'h0002, 4'h0);
    check_obs(1, 16'h0FF0, 4'h0);
    check_obs(2, 16'hF000, 4'h8);
    if (obs_q.size() == 3) begin
      chk("bp_gap01", obs_q[1].cyc - obs_q[0].cyc, 32'd1);
      chk("bp_gap12", obs_q[2].cyc - obs_q[1].cyc, 32'd1);
    end

    // Reset with both registers full.
    @(negedge clk);
    out_ready = 1'b0;
    issue(ADD, 16'hFFFF, 16'h0001);
    issue(ADD, 16'h0001, 16'h0002);
    @(negedge clk);
    #1;
    chk("pre_rst_carry", 32'(carry_flag), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_carry", 32'(carry_flag), 32'd0);
    exp_q.delete();
    m_cf = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    obs_q.delete();
    issue(ADC, 16'h0001, 16'h0001);
    drain();
    chk("post_rst_count", 32'(obs_q.size()), 32'd1);
    check_obs(0, 16'h0002, 4'h0);

    // Randomized traffic with random backpressure and idle cycles.
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else issue(3'($urandom_range(0, 7)), rnd16(), rnd16());
    end
    rand_ready = 1'b0;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
